// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - two-state cache line fill sequencer (8 reads out, 8 words back)
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_WIDTH-1:0] miss_address,
  input  logic                  memory_data_valid,
  input  logic [DATA_WIDTH-1:0] memory_data_in,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] memory_address,
  output logic [2:0]            fill_offset,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  write_data_array,
  output logic                  write_tag_array
);

  localparam int LINE_W = ADDR_WIDTH - 4;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   base_line_q, base_line_d;
  logic [2:0]          req_cnt_q, req_cnt_d;
  logic                req_done_q, req_done_d;
  logic [2:0]          rcv_cnt_q, rcv_cnt_d;

  // Byte and word-offset bits of the miss address never reach the line base.
  logic unused_addr_bits;
  assign unused_addr_bits = ^miss_address[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_line_q <= '0;
      req_cnt_q   <= 3'd0;
      req_done_q  <= 1'b0;
      rcv_cnt_q   <= 3'd0;
    end else begin
      state_q     <= state_d;
      base_line_q <= base_line_d;
      req_cnt_q   <= req_cnt_d;
      req_done_q  <= req_done_d;
      rcv_cnt_q   <= rcv_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    base_line_d      = base_line_q;
    req_cnt_d        = req_cnt_q;
    req_done_d       = req_done_q;
    rcv_cnt_d        = rcv_cnt_q;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    fill_offset      = 3'd0;
    fill_data        = '0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;

    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          state_d     = FILL;
          base_line_d = miss_address[ADDR_WIDTH-1:4];
          req_cnt_d   = 3'd0;
          req_done_d  = 1'b0;
          rcv_cnt_d   = 3'd0;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // Request path runs ahead of returns; it parks on req_done instead of wrapping.
        if (!req_done_q) begin
          mem_read_en    = 1'b1;
          memory_address = {base_line_q, req_cnt_q, 1'b0};
          if (req_cnt_q == 3'd7) begin
            req_done_d = 1'b1;
          end else begin
            req_cnt_d = req_cnt_q + 3'd1;
          end
        end

        write_data_array = memory_data_valid;
        fill_offset      = rcv_cnt_q;
        fill_data        = memory_data_in;
        if (memory_data_valid) begin
          if (rcv_cnt_q == 3'd7) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end else begin
            rcv_cnt_d = rcv_cnt_q + 3'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb/tb_cache_fill_fsm.sv - self-checking bench for cache_fill_fsm with in-order memory model
module tb_cache_fill_fsm;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          miss_detected;
  logic [AW-1:0] miss_address;
  logic          memory_data_valid;
  logic [DW-1:0] memory_data_in;
  logic          fsm_busy;
  logic          mem_read_en;
  logic [AW-1:0] memory_address;
  logic [2:0]    fill_offset;
  logic [DW-1:0] fill_data;
  logic          write_data_array;
  logic          write_tag_array;

  cache_fill_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .memory_data_valid(memory_data_valid),
    .memory_data_in   (memory_data_in),
    .fsm_busy         (fsm_busy),
    .mem_read_en      (mem_read_en),
    .memory_address   (memory_address),
    .fill_offset      (fill_offset),
    .fill_data        (fill_data),
    .write_data_array (write_data_array),
    .write_tag_array  (write_tag_array)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: is a fill open, which line, how many reads issued, how many words received.
  bit m_busy;
  int m_base;
  int m_reads;
  int m_rets;

  // Memory: in-order return queue, each entry ready no earlier than issue + lat.
  int pend_ready[$];
  int pend_addr[$];
  int last_ready;
  int cyc;
  int lat;
  int spacing;
  int jitter;
  bit inject;

  int n_reads;
  int n_writes;
  int n_tags;
  int n_busy;
  int addr_log[$];

  function automatic logic [DW-1:0] word_of(input int a);
    logic [31:0] t;
    t = (a * 32'h9E37) ^ 32'h5A5A;
    return t[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_stats();
    n_reads = 0;
    n_writes = 0;
    n_tags = 0;
    n_busy = 0;
    addr_log.delete();
  endtask

  task automatic step();
    bit e_rd;
    bit e_wr;
    int e_addr;
    int r;
    @(negedge clk);
    e_rd   = m_busy && (m_reads < 8);
    e_addr = (m_base * 16) + (m_reads * 2);
    e_wr   = m_busy && memory_data_valid;
    chk("busy", fsm_busy, m_busy);
    chk("rd_en", mem_read_en, e_rd);
    if (e_rd) chk("rd_addr", memory_address, e_addr);
    chk("wr_data", write_data_array, e_wr);
    chk("wr_tag", write_tag_array, e_wr && (m_rets == 7));
    chk("offset", fill_offset, m_busy ? m_rets : 0);
    chk("fill_data", fill_data, m_busy ? memory_data_in : '0);
    if (mem_read_en) begin
      n_reads++;
      addr_log.push_back(int'(memory_address));
      r = cyc + lat + $urandom_range(0, jitter);
      if (r < last_ready + spacing) r = last_ready + spacing;
      pend_ready.push_back(r);
      pend_addr.push_back(int'(memory_address));
      last_ready = r;
    end
    n_writes += int'(write_data_array);
    n_tags   += int'(write_tag_array);
    n_busy   += int'(fsm_busy);
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (miss_detected) begin
        m_busy  = 1'b1;
        m_base  = int'(miss_address) / 16;
        m_reads = 0;
        m_rets  = 0;
      end
    end else begin
      if (m_reads < 8) m_reads++;
      if (memory_data_valid) begin
        if (m_rets == 7) m_busy = 1'b0;
        else m_rets++;
      end
    end
    cyc++;
    #1;
    if (pend_ready.size() > 0 && pend_ready[0] <= cyc) begin
      memory_data_valid = 1'b1;
      memory_data_in    = word_of(pend_addr[0]);
      void'(pend_ready.pop_front());
      void'(pend_addr.pop_front());
    end else if (inject) begin
      memory_data_valid = 1'b1;
      memory_data_in    = DW'($urandom);
      inject            = 1'b0;
    end else begin
      memory_data_valid = 1'b0;
      memory_data_in    = DW'($urandom);
    end
  endtask

  task automatic start_fill(input logic [AW-1:0] a);
    miss_detected = 1'b1;
    miss_address  = a;
    step();
    miss_detected = 1'b0;
  endtask

  task automatic run_until_idle(input int bound);
    int k;
    k = 0;
    while (m_busy && k < bound) begin
      step();
      k++;
    end
    chk("fill_timeout", m_busy, 0);
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (pend_ready.size() > 0 && k < bound) begin
      step();
      k++;
    end
    chk("drain_timeout", pend_ready.size(), 0);
  endtask

  initial begin
    int k;
    int rst_at;
    bit do_rst;
    rst = 1'b1;
    miss_detected = 1'b0;
    miss_address = '0;
    memory_data_valid = 1'b0;
    memory_data_in = '0;
    m_busy = 1'b0; m_base = 0; m_reads = 0; m_rets = 0;
    last_ready = 0; cyc = 0; lat = 1; spacing = 1; jitter = 0; inject = 1'b0;
    reset_stats();
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    chk("reset_busy", fsm_busy, 0);
    chk("reset_rd", mem_read_en, 0);
    chk("reset_tag", write_tag_array, 0);

    // Reference fill: latency 4, back-to-back returns.
    lat = 4; spacing = 1; jitter = 0;
    reset_stats();
    start_fill(16'h1236);
    run_until_idle(100);
    chk("ref_reads", n_reads, 8);
    chk("ref_writes", n_writes, 8);
    chk("ref_tags", n_tags, 1);
    chk("ref_busy_cycles", n_busy, 12);
    chk("ref_addr_count", addr_log.size(), 8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++)
      chk("ref_addr", addr_log[i], 32'h1230 + 2 * i);

    // Returns on every other cycle.
    lat = 1; spacing = 2;
    reset_stats();
    start_fill(AW'($urandom));
    run_until_idle(100);
    chk("gap_writes", n_writes, 8);
    chk("gap_tags", n_tags, 1);
    chk("gap_idle", fsm_busy, 0);

    // Miss held through the fill, then immediate refill.
    lat = 2; spacing = 1; jitter = 2;
    reset_stats();
    miss_detected = 1'b1;
    miss_address  = AW'($urandom);
    step();
    run_until_idle(100);
    chk("held_reads", n_reads, 8);
    chk("held_tags", n_tags, 1);
    step();
    chk("held_refill_busy", fsm_busy, 1);
    miss_detected = 1'b0;
    run_until_idle(100);
    chk("held_total_reads", n_reads, 16);

    // Reset after the third return.
    lat = 3; spacing = 2; jitter = 0;
    reset_stats();
    start_fill(AW'($urandom));
    k = 0;
    while (n_writes < 3 && k < 50) begin
      step();
      k++;
    end
    chk("rst_reach3", n_writes, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", fsm_busy, 0);
    drain(60);
    chk("rst_writes", n_writes, 3);
    chk("rst_tags", n_tags, 0);

    // Stray return while idle.
    reset_stats();
    inject = 1'b1;
    step();
    step();
    chk("idle_inject_wr", n_writes, 0);
    chk("idle_inject_busy", fsm_busy, 0);

    // Line-address boundary, back to back.
    lat = 1; spacing = 1; jitter = 1;
    reset_stats();
    start_fill(16'hFFF0);
    run_until_idle(100);
    start_fill(16'h0000);
    run_until_idle(100);
    chk("wrap_addr_count", addr_log.size(), 16);
    for (int i = 0; i < 16 && i < addr_log.size(); i++)
      chk("wrap_addr", addr_log[i], (i < 8) ? (32'hFFF0 + 2 * i) : (2 * (i - 8)));

    // Randomized fills with noisy miss input and occasional resets.
    for (int n = 0; n < 25; n++) begin
      lat     = $urandom_range(1, 5);
      jitter  = $urandom_range(0, 3);
      spacing = $urandom_range(1, 2);
      do_rst  = ($urandom_range(0, 4) == 0);
      rst_at  = $urandom_range(0, 12);
      reset_stats();
      start_fill(AW'($urandom));
      k = 0;
      while (m_busy && k < 200) begin
        miss_detected = 1'($urandom_range(0, 1));
        miss_address  = AW'($urandom);
        if (do_rst && k == rst_at) rst = 1'b1;
        step();
        rst = 1'b0;
        k++;
      end
      miss_detected = 1'b0;
      chk("rand_timeout", m_busy, 0);
      drain(100);
      if (!do_rst) begin
        chk("rand_reads", n_reads, 8);
        chk("rand_tags", n_tags, 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, sets the byte-address width.
REQ-002 Parameter DATA_WIDTH, default 16, sets the memory word width.
REQ-003 Address layout SHALL be fixed: [0] byte, [3:1] word offset (8 words/line), [ADDR_WIDTH-1:4] line address.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 miss_detected  input  1  cache miss present; fill requested.
REQ-007 miss_address  input  ADDR_WIDTH  byte address of the missing access.
REQ-008 memory_data_valid  input  1  memory returns one word this cycle.
REQ-009 memory_data_in  input  DATA_WIDTH  returned word; valid only with memory_data_valid.
REQ-010 fsm_busy  output  1  fill in progress; stalls the pipeline.
REQ-011 mem_read_en  output  1  issue one memory read this cycle.
REQ-012 memory_address  output  ADDR_WIDTH  read address issued with mem_read_en.
REQ-013 fill_offset  output  3  word index of the returning word; drives the word-enable decoder.
REQ-014 fill_data  output  DATA_WIDTH  word to write into the data array.
REQ-015 write_data_array  output  1  data-array write strobe for fill_offset/fill_data.
REQ-016 write_tag_array  output  1  one-cycle tag/valid write at fill completion.

Function
REQ-017 The FSM SHALL have two states: IDLE and FILL.
REQ-018 IDLE -> FILL SHALL occur on a clock edge where miss_detected=1; the FSM SHALL latch miss_address[ADDR_WIDTH-1:4] as base_line.
REQ-019 In IDLE, miss_detected=0 SHALL hold IDLE; memory_data_valid SHALL be ignored.
REQ-020 In FILL, fsm_busy SHALL be 1; in IDLE, fsm_busy SHALL be 0 (combinational from state).
REQ-021 A 3-bit request counter req_cnt and a done flag req_done SHALL be cleared on IDLE->FILL.
REQ-022 In FILL with req_done=0: mem_read_en=1, memory_address={base_line, req_cnt, 1'b0}; req_cnt increments each cycle.
REQ-023 When req_cnt=7 and a read issues, req_done SHALL set; no further reads in this fill (exactly 8 reads total).
REQ-024 Words SHALL return in request order; memory latency is arbitrary but at least 1 cycle; the FSM SHALL NOT assume a fixed latency.
REQ-025 A 3-bit receive counter rcv_cnt SHALL be cleared on IDLE->FILL and increment on each memory_data_valid in FILL.
REQ-026 In FILL, write_data_array SHALL equal memory_data_valid, fill_offset=rcv_cnt, and fill_data=memory_data_in (combinational, same cycle).
REQ-027 When memory_data_valid=1 and rcv_cnt=7 in FILL, write_tag_array SHALL be 1 that cycle and the next state SHALL be IDLE.
REQ-028 miss_detected while in FILL SHALL be ignored; a new fill starts only from IDLE.
REQ-029 Counters SHALL NOT wrap within a fill: the request path stops on req_done, and the receive path exits on the 8th word.
REQ-030 In IDLE, mem_read_en, write_data_array, and write_tag_array SHALL be 0; fill_offset and fill_data SHALL be 0.
REQ-031 If miss_detected=1 on the completion cycle, the FSM SHALL return to IDLE first; the next fill starts no earlier than the following edge.

Reset
REQ-032 With rst=1 at a clock edge, next state SHALL be IDLE, with req_cnt=0, rcv_cnt=0, req_done=0, and base_line=0.
REQ-033 During and after reset, all outputs SHALL take their IDLE values (REQ-020, REQ-030).
REQ-034 Reset mid-fill SHALL abort the fill with no write_tag_array pulse; memory returns arriving after reset SHALL be ignored.

Verification
REQ-035 Miss at miss_address=16'h1236, memory latency 4 -> memory_address 16'h1230,1232,...,123E on 8 consecutive cycles; fill_offset 0..7 with write_data_array; write_tag_array on the 8th return; fsm_busy high for 12 cycles.
REQ-036 Returns gapped (valid every other cycle) -> 8 data writes with offsets 0..7 in order, a single write_tag_array pulse, then IDLE.
REQ-037 miss_detected held high throughout the fill -> exactly 8 reads, no restart mid-fill; a second fill starts the cycle after returning to IDLE.
REQ-038 rst asserted after the 3rd return -> next cycle IDLE, fsm_busy=0; remaining memory_data_valid pulses produce no writes and no tag write.
REQ-039 memory_data_valid pulsed while IDLE -> write_data_array=0, rcv_cnt unchanged, no state change.
REQ-040 Back-to-back misses at 16'hFFF0 then 16'h0000 -> addresses FFF0..FFFE, then 0000..000E, with no carry from word offset into line address.
